// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// forwards EX/MEM and MEM/WB results onto the operands, and detects load-use hazards.
module id_ex_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [REG_ADDR-1:0]      id_rs1,
    input  logic [REG_ADDR-1:0]      id_rs2,
    input  logic [REG_ADDR-1:0]      id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic [2:0]               id_ctrl,
    input  logic                     exmem_reg_write,
    input  logic [REG_ADDR-1:0]      exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [REG_ADDR-1:0]      memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     stall,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR-1:0]      ex_rd,
    output logic [2:0]               ex_ctrl
);

    localparam logic [REG_ADDR-1:0] REG_ZERO = {REG_ADDR{1'b0}};

    logic                     valid_r;
    logic [REG_ADDR-1:0]      rs1_r;
    logic [REG_ADDR-1:0]      rs2_r;
    logic [REG_ADDR-1:0]      rd_r;
    logic [DATA_WIDTH-1:0]    rs1_data_r;
    logic [DATA_WIDTH-1:0]    rs2_data_r;
    logic [DATA_WIDTH-1:0]    imm_r;
    logic                     alu_src_r;
    logic [OPCODE_LENGTH-1:0] alu_op_r;
    logic [2:0]               ctrl_r;

    logic                     load_use_s;
    logic                     stall_s;
    logic [DATA_WIDTH-1:0]    fwd1_s;
    logic [DATA_WIDTH-1:0]    fwd2_s;

    // Newer producer (EX/MEM) wins; x0 is hard-wired and never forwarded.
    function automatic logic [DATA_WIDTH-1:0] forward_operand(
        input logic [REG_ADDR-1:0]   rs,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  em_we,
        input logic [REG_ADDR-1:0]   em_rd,
        input logic [DATA_WIDTH-1:0] em_res,
        input logic                  mw_we,
        input logic [REG_ADDR-1:0]   mw_rd,
        input logic [DATA_WIDTH-1:0] mw_res
    );
        logic [DATA_WIDTH-1:0] r;
        if (em_we && (em_rd != REG_ZERO) && (em_rd == rs)) begin
            r = em_res;
        end else if (mw_we && (mw_rd != REG_ZERO) && (mw_rd == rs)) begin
            r = mw_res;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Load-use hazard detection; a flush overrides it since ID is wrong-path.
    always_comb begin
        load_use_s = id_valid && valid_r && ctrl_r[1] && (rd_r != REG_ZERO) &&
                     ((id_rs1 == rd_r) || (id_rs2 == rd_r));
        if (flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = load_use_s;
        end
    end

    // Stage register: reset > flush > stall > normal capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r    <= 1'b0;
            rs1_r      <= REG_ZERO;
            rs2_r      <= REG_ZERO;
            rd_r       <= REG_ZERO;
            rs1_data_r <= {DATA_WIDTH{1'b0}};
            rs2_data_r <= {DATA_WIDTH{1'b0}};
            imm_r      <= {DATA_WIDTH{1'b0}};
            alu_src_r  <= 1'b0;
            alu_op_r   <= {OPCODE_LENGTH{1'b0}};
            ctrl_r     <= 3'b000;
        end else if (flush || stall_s) begin
            valid_r  <= 1'b0;
            rd_r     <= REG_ZERO;
            alu_op_r <= {OPCODE_LENGTH{1'b0}};
            ctrl_r   <= 3'b000;
        end else begin
            valid_r    <= id_valid;
            rs1_r      <= id_rs1;
            rs2_r      <= id_rs2;
            rd_r       <= id_rd;
            rs1_data_r <= id_rs1_data;
            rs2_data_r <= id_rs2_data;
            imm_r      <= id_imm;
            alu_src_r  <= id_alu_src;
            alu_op_r   <= id_valid ? id_alu_op : {OPCODE_LENGTH{1'b0}};
            ctrl_r     <= id_valid ? id_ctrl : 3'b000;
        end
    end

    // Operand forwarding on the registered source indices.
    always_comb begin
        fwd1_s = forward_operand(rs1_r, rs1_data_r, exmem_reg_write, exmem_rd, exmem_result,
                                 memwb_reg_write, memwb_rd, memwb_result);
        fwd2_s = forward_operand(rs2_r, rs2_data_r, exmem_reg_write, exmem_rd, exmem_result,
                                 memwb_reg_write, memwb_rd, memwb_result);
    end

    assign stall         = stall_s;
    assign ex_valid      = valid_r;
    assign SrcA          = fwd1_s;
    assign SrcB          = alu_src_r ? imm_r : fwd2_s;
    assign Operation     = alu_op_r;
    assign ex_store_data = fwd2_s;
    assign ex_rd         = rd_r;
    assign ex_ctrl       = ctrl_r;

endmodule
